// File: rtl/key_conditioner_pkg.sv
// Shared constants for the pushbutton input stage and the rocket control path.
package key_conditioner_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DFLT      = 1_000_000;   // 20 ms at 50 MHz
    localparam int unsigned REPEAT_DELAY_CYCLES_DFLT  = 25_000_000;  // 0.5 s at 50 MHz
    localparam int unsigned REPEAT_PERIOD_CYCLES_DFLT = 12_500_000;  // 0.25 s at 50 MHz
    localparam int unsigned CNT_W_DFLT                = 25;

    // Control-path rate limiting between consecutive rocket moves
    localparam int unsigned MOVE_RATE_LIMIT_CYCLES    = 2_500_000;
    localparam int unsigned MOVE_RATE_CNT_W           = 22;

    localparam int unsigned RPT_ST_W = 2;
    localparam logic [1:0]  RPT_IDLE   = 2'd0;
    localparam logic [1:0]  RPT_DELAY  = 2'd1;
    localparam logic [1:0]  RPT_REPEAT = 2'd2;

endpackage

// File: rtl/key_channel.sv
// One pushbutton: two-flop synchroniser, debouncer, press-edge detect and optional auto-repeat.
module key_channel
    import key_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES      = DEBOUNCE_CYCLES_DFLT,
    parameter int unsigned REPEAT_DELAY_CYCLES  = REPEAT_DELAY_CYCLES_DFLT,
    parameter int unsigned REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_CYCLES_DFLT,
    parameter int unsigned CNT_W                = CNT_W_DFLT,
    parameter bit          REPEAT_EN            = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_event
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD_CYCLES - 1);

    logic [1:0]          r_sync;
    logic                w_raw;
    logic                r_stable;
    logic                r_stable_d;
    logic [CNT_W-1:0]    r_dcnt;
    logic [RPT_ST_W-1:0] r_state;
    logic [RPT_ST_W-1:0] w_state_nxt;
    logic [CNT_W-1:0]    r_rcnt;
    logic [CNT_W-1:0]    w_rcnt_nxt;
    logic                w_rise;
    logic                w_rep;
    logic                r_event;

    // Pins idle high, so reset loads "released" into the synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], i_key_n};
    end

    assign w_raw = ~r_sync[1];

    // Accept a new level only after it has differed from the stable one for DEBOUNCE_CYCLES
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_dcnt     <= '0;
        end else begin
            r_stable_d <= r_stable;
            if (w_raw == r_stable) begin
                r_dcnt <= '0;
            end else if (r_dcnt == DB_LAST) begin
                r_stable <= w_raw;
                r_dcnt   <= '0;
            end else begin
                r_dcnt <= r_dcnt + CNT_W'(1);
            end
        end
    end

    assign w_rise = r_stable & ~r_stable_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RPT_IDLE;
            r_rcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rcnt  <= w_rcnt_nxt;
        end
    end

    // Repeat timer; a release seen on the terminal cycle wins over the repeat
    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_rep       = 1'b0;
        case (r_state)
            RPT_IDLE: begin
                if (REPEAT_EN && w_rise) begin
                    w_state_nxt = RPT_DELAY;
                    w_rcnt_nxt  = '0;
                end
            end
            RPT_DELAY: begin
                if (!r_stable) begin
                    w_state_nxt = RPT_IDLE;
                    w_rcnt_nxt  = '0;
                end else if (r_rcnt == RD_LAST) begin
                    w_rep       = 1'b1;
                    w_state_nxt = RPT_REPEAT;
                    w_rcnt_nxt  = '0;
                end else begin
                    w_rcnt_nxt = r_rcnt + CNT_W'(1);
                end
            end
            RPT_REPEAT: begin
                if (!r_stable) begin
                    w_state_nxt = RPT_IDLE;
                    w_rcnt_nxt  = '0;
                end else if (r_rcnt == RP_LAST) begin
                    w_rep      = 1'b1;
                    w_rcnt_nxt = '0;
                end else begin
                    w_rcnt_nxt = r_rcnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = RPT_IDLE;
                w_rcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_event <= 1'b0;
        else        r_event <= w_rise | w_rep;
    end

    assign o_event = r_event;

endmodule

// File: rtl/key_conditioner.sv
// KEY input stage: three conditioned buttons feeding depth-1 pending left/right requests and a start pulse.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES      = DEBOUNCE_CYCLES_DFLT,
    parameter int unsigned REPEAT_DELAY_CYCLES  = REPEAT_DELAY_CYCLES_DFLT,
    parameter int unsigned REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_CYCLES_DFLT,
    parameter int unsigned CNT_W                = CNT_W_DFLT
) (
    input  logic clk,
    input  logic reset,
    input  logic key_start_n,
    input  logic key_left_n,
    input  logic key_right_n,
    input  logic consume,
    input  logic flush,
    output logic start,
    output logic left,
    output logic right
);

    logic w_ev_start;
    logic w_ev_left;
    logic w_ev_right;
    logic r_start;
    logic r_left_pend;
    logic r_right_pend;
    logic r_right;
    logic w_left_pend_nxt;
    logic w_right_pend_nxt;

    key_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
        .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES), .CNT_W(CNT_W), .REPEAT_EN(1'b0)
    ) u_start (.clk(clk), .rst_n(reset), .i_key_n(key_start_n), .o_event(w_ev_start));

    key_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
        .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES), .CNT_W(CNT_W), .REPEAT_EN(1'b1)
    ) u_left (.clk(clk), .rst_n(reset), .i_key_n(key_left_n), .o_event(w_ev_left));

    key_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
        .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES), .CNT_W(CNT_W), .REPEAT_EN(1'b1)
    ) u_right (.clk(clk), .rst_n(reset), .i_key_n(key_right_n), .o_event(w_ev_right));

    // Set beats clear; clear only applies to the request currently visible on the outputs
    always_comb begin
        w_left_pend_nxt  = r_left_pend;
        w_right_pend_nxt = r_right_pend;
        if (flush) begin
            w_left_pend_nxt  = 1'b0;
            w_right_pend_nxt = 1'b0;
        end else begin
            if (w_ev_left)                   w_left_pend_nxt = 1'b1;
            else if (consume && r_left_pend) w_left_pend_nxt = 1'b0;
            if (w_ev_right)                  w_right_pend_nxt = 1'b1;
            else if (consume && r_right)     w_right_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start      <= 1'b0;
            r_left_pend  <= 1'b0;
            r_right_pend <= 1'b0;
            r_right      <= 1'b0;
        end else begin
            r_start      <= w_ev_start & ~flush;
            r_left_pend  <= w_left_pend_nxt;
            r_right_pend <= w_right_pend_nxt;
            r_right      <= w_right_pend_nxt & ~w_left_pend_nxt;
        end
    end

    assign start = r_start;
    assign left  = r_left_pend;
    assign right = r_right;

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
Input stage between the board pushbuttons (KEY, active-low) and the rocket control path. It synchronises, debounces and edge-detects three keys and provides auto-repeat for left/right. Left/right requests are held as pending until the control path consumes them in its intake state, so no press is lost while a move is being drawn. Its start/left/right outputs drive the rocket block's start/left/right inputs directly.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, cycles a synchronised level must be stable before acceptance (20 ms at 50 MHz).
REPEAT_DELAY_CYCLES, 25_000_000, hold time from accepted press to first repeat event (0.5 s).
REPEAT_PERIOD_CYCLES, 12_500_000, spacing of subsequent repeat events (0.25 s).
CNT_W, 25, width of all internal counters; must hold the largest cycle parameter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
key_start_n  in  1  raw start pushbutton, low = pressed, asynchronous to clk
key_left_n  in  1  raw left pushbutton, low = pressed
key_right_n  in  1  raw right pushbutton, low = pressed
consume  in  1  control path is in intake state (inIntake); a visible left/right is taken this cycle
flush  in  1  synchronous clear of pending requests; events ignored while high
start  out  1  one-cycle pulse per accepted start press
left  out  1  pending left move request (level)
right  out  1  pending right move request (level)

Behaviour:
- Reset is asynchronous and active-low. While reset is low: start=0, left=0, right=0, all pending bits 0, all counters 0. Synchroniser and debounced states load "released".
- Synchroniser: 2 flops per key, then invert to active-high raw.
- Debounce, per key: counter clears whenever raw==stable. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, stable<=raw and counter<=0. Any glitch shorter than DEBOUNCE_CYCLES produces no change.
- Press event = stable rising. Latency from the first edge sampling a pin low (pin steady) to the event is exactly DEBOUNCE_CYCLES+3 cycles. Release has no event.
- Repeat FSM, left/right channels only. States:
  - IDLE → DELAY on press event.
  - DELAY: counts cycles. On reaching REPEAT_DELAY_CYCLES, emits a repeat event and goes to REPEAT.
  - REPEAT: emits an event every REPEAT_PERIOD_CYCLES.
  - DELAY/REPEAT → IDLE on stable fall. A release in the same cycle as the terminal count suppresses that event.
  - Start channel has no repeat.
- start: registered one-cycle pulse on start press event. Not gated by consume; it is gated by flush.
- Pending, depth 1 per direction:
  - An event sets pend. An event while pend=1 is dropped; there is no queue.
  - Clear when consume=1 and the corresponding output is 1 in that cycle.
  - If an event and a clear occur in the same cycle, set wins.
- Output priority: left = left_pend; right = right_pend & ~left_pend. When both are pending, left is served first; right becomes visible the cycle after left is consumed.
- flush=1: both pend<=0, start held 0, new events discarded. Debounce and repeat counters keep running, so a key held through flush does not re-fire until its next repeat event.
- Reset mid-press: after reset deasserts with the key still held, stable rises after the debounce window and a fresh press event is generated (intentional).

Decomposition:
- Shared package: default cycle constants (DEBOUNCE, REPEAT_DELAY, REPEAT_PERIOD at 50 MHz) and repeat FSM state encodings (IDLE, DELAY, REPEAT). The rate-limit timing constants used by the control path belong in the same package.
- One sub-module, key_channel (sync + debounce + optional repeat, parameter REPEAT_EN). It is instantiated three times. The top holds the pending/priority/flush logic.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_PERIOD_CYCLES=8):
- Clean start: key_start_n low at edge 10, held 30 cycles → start=1 exactly at cycle 17 for one cycle, no further pulses; release produces nothing.
- Bounce rejection: key_left_n toggles with pulses of 3 cycles for 40 cycles, then held low → single left assertion 7 cycles after the final low edge; no earlier assertion.
- Pending/consume: left press with consume=0 for 50 cycles → left stays 1, and no second assertion after repeats (dropped). consume=1 one cycle → left=0 next cycle.
- Auto-repeat: hold right with consume tied 1 → right events at press+7, +27, +35, +43…; stop within one period after release, with no event in the release cycle.
- Simultaneous: left and right events in the same cycle, consume=1 → left visible first; right=1 the cycle after left is consumed; each consumed once.
- flush and async reset: pending left with flush=1 → left=0 next cycle, events during flush are lost. Reset low mid-DELAY → all outputs 0 immediately (asynchronous). After release with the key still held → new event after 7 cycles.
